// File: rtl/code_entry.sv
// Digit-by-digit code entry: dial a BCD digit with increment pulses, commit it with load,
// and present the completed code until the consumer acknowledges it.
module code_entry #(
  parameter int NUM_DIGITS     = 4,
  parameter int MAX_DIGIT      = 9,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc_pulse,
  input  logic                    load_pulse,
  input  logic                    clear_pulse,
  input  logic                    code_ack,
  output logic [3:0]              digit_out,
  output logic [2:0]              digit_count,
  output logic [4*NUM_DIGITS-1:0] code_out,
  output logic                    code_valid,
  output logic                    timeout
);

  localparam int CW     = 4 * NUM_DIGITS;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {ENTRY, VALID} state_t;

  state_t            r_state, w_state_next;
  logic [3:0]        r_digit, w_digit_next;
  logic [2:0]        r_count, w_count_next;
  logic [CW-1:0]     r_code, w_code_next;
  logic              r_valid, w_valid_next;
  logic              r_timeout, w_timeout_next;
  logic [IDLE_W-1:0] r_idle, w_idle_next;

  logic [CW+3:0]     w_cat;
  logic              w_busy;

  // Concatenate-then-truncate keeps the shift legal even for a single-digit code.
  assign w_cat  = {r_code, r_digit};
  assign w_busy = (r_count != 3'd0) || (r_digit != 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ENTRY;
      r_digit   <= 4'd0;
      r_count   <= 3'd0;
      r_code    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_idle    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_digit   <= w_digit_next;
      r_count   <= w_count_next;
      r_code    <= w_code_next;
      r_valid   <= w_valid_next;
      r_timeout <= w_timeout_next;
      r_idle    <= w_idle_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_digit_next   = r_digit;
    w_count_next   = r_count;
    w_code_next    = r_code;
    w_valid_next   = r_valid;
    w_timeout_next = 1'b0;
    w_idle_next    = '0;

    case (r_state)
      ENTRY: begin
        if (clear_pulse) begin
          w_digit_next = 4'd0;
          w_count_next = 3'd0;
          w_code_next  = '0;
          w_valid_next = 1'b0;
        end else if (load_pulse) begin
          // A coincident increment is dropped: the pre-increment digit is committed.
          w_code_next  = w_cat[CW-1:0];
          w_count_next = r_count + 3'd1;
          w_digit_next = 4'd0;
          if (r_count == 3'(NUM_DIGITS - 1)) begin
            w_state_next = VALID;
            w_valid_next = 1'b1;
          end
        end else if (inc_pulse) begin
          w_digit_next = (r_digit == 4'(MAX_DIGIT)) ? 4'd0 : r_digit + 4'd1;
        end else if (w_busy) begin
          if (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
            w_digit_next   = 4'd0;
            w_count_next   = 3'd0;
            w_code_next    = '0;
            w_timeout_next = 1'b1;
          end else begin
            w_idle_next = r_idle + 1'b1;
          end
        end
      end
      VALID: begin
        if (clear_pulse || code_ack) begin
          w_state_next = ENTRY;
          w_digit_next = 4'd0;
          w_count_next = 3'd0;
          w_code_next  = '0;
          w_valid_next = 1'b0;
        end
      end
      default: w_state_next = ENTRY;
    endcase
  end

  assign digit_out   = r_digit;
  assign digit_count = r_count;
  assign code_out    = r_code;
  assign code_valid  = r_valid;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_code_entry.sv
// Directed bench for code_entry with NUM_DIGITS=4, MAX_DIGIT=9, TIMEOUT_CYCLES=8.
module tb_code_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic        inc_pulse, load_pulse, clear_pulse, code_ack;
  logic [3:0]  digit_out;
  logic [2:0]  digit_count;
  logic [15:0] code_out;
  logic        code_valid, timeout;

  int n_checks = 0;
  int n_fail   = 0;

  code_entry #(.NUM_DIGITS(4), .MAX_DIGIT(9), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .inc_pulse(inc_pulse), .load_pulse(load_pulse),
    .clear_pulse(clear_pulse), .code_ack(code_ack),
    .digit_out(digit_out), .digit_count(digit_count),
    .code_out(code_out), .code_valid(code_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        inc, load, clr, ack;
    logic [3:0]  d;
    logic [2:0]  c;
    logic [15:0] code;
    logic        v, t;
  } vec_t;

  vec_t vecs[$];

  task automatic push(string name, logic inc, logic load, logic clr, logic ack,
                      logic [3:0] d, logic [2:0] c, logic [15:0] code, logic v, logic t);
    vec_t x;
    x.name = name; x.inc = inc; x.load = load; x.clr = clr; x.ack = ack;
    x.d = d; x.c = c; x.code = code; x.v = v; x.t = t;
    vecs.push_back(x);
  endtask

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_all(string name, logic [3:0] d, logic [2:0] c,
                            logic [15:0] code, logic v, logic t);
    cmp({name, ".digit_out"},   32'(digit_out),   32'(d));
    cmp({name, ".digit_count"}, 32'(digit_count), 32'(c));
    cmp({name, ".code_out"},    32'(code_out),    32'(code));
    cmp({name, ".code_valid"},  32'(code_valid),  32'(v));
    cmp({name, ".timeout"},     32'(timeout),     32'(t));
    $display("txn %-14s d=%0d cnt=%0d code=%04h valid=%0b tmo=%0b",
             name, digit_out, digit_count, code_out, code_valid, timeout);
  endtask

  // Apply inputs for one clock edge and leave them low afterwards; returns 1 ns after the edge.
  task automatic step(logic inc, logic load, logic clr, logic ack);
    inc_pulse = inc; load_pulse = load; clear_pulse = clr; code_ack = ack;
    @(posedge clk);
    #1;
    inc_pulse = 0; load_pulse = 0; clear_pulse = 0; code_ack = 0;
  endtask

  initial begin
    rst = 1'b1;
    inc_pulse = 0; load_pulse = 0; clear_pulse = 0; code_ack = 0;

    // Dial 3,0,7,1; the final digit is committed with inc+load together.
    push("inc1",      1,0,0,0, 4'd1, 3'd0, 16'h0000, 0, 0);
    push("inc2",      1,0,0,0, 4'd2, 3'd0, 16'h0000, 0, 0);
    push("inc3",      1,0,0,0, 4'd3, 3'd0, 16'h0000, 0, 0);
    push("load3",     0,1,0,0, 4'd0, 3'd1, 16'h0003, 0, 0);
    push("load0",     0,1,0,0, 4'd0, 3'd2, 16'h0030, 0, 0);
    for (int i = 1; i <= 7; i++)
      push("inc_to7", 1,0,0,0, 4'(i), 3'd2, 16'h0030, 0, 0);
    push("load7",     0,1,0,0, 4'd0, 3'd3, 16'h0307, 0, 0);
    push("inc_to1",   1,0,0,0, 4'd1, 3'd3, 16'h0307, 0, 0);
    push("inc_load",  1,1,0,0, 4'd0, 3'd4, 16'h3071, 1, 0);
    push("v_inc",     1,0,0,0, 4'd0, 3'd4, 16'h3071, 1, 0);
    push("v_load",    0,1,0,0, 4'd0, 3'd4, 16'h3071, 1, 0);
    push("v_hold",    0,0,0,0, 4'd0, 3'd4, 16'h3071, 1, 0);
    push("ack",       0,0,0,1, 4'd0, 3'd0, 16'h0000, 0, 0);
    push("e_inc",     1,0,0,0, 4'd1, 3'd0, 16'h0000, 0, 0);
    push("e_ack_ign", 0,0,0,1, 4'd1, 3'd0, 16'h0000, 0, 0);
    push("e_clear",   1,1,1,0, 4'd0, 3'd0, 16'h0000, 0, 0);

    #12;
    expect_all("reset", 4'd0, 3'd0, 16'h0000, 0, 0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      step(vecs[k].inc, vecs[k].load, vecs[k].clr, vecs[k].ack);
      expect_all(vecs[k].name, vecs[k].d, vecs[k].c, vecs[k].code, vecs[k].v, vecs[k].t);
    end

    // Digit wrap: 9 then 0 after 10 pulses, 1 after 11.
    for (int i = 1; i <= 11; i++) begin
      step(1,0,0,0);
      if (i == 9)  expect_all("wrap9",  4'd9, 3'd0, 16'h0000, 0, 0);
      if (i == 10) expect_all("wrap10", 4'd0, 3'd0, 16'h0000, 0, 0);
      if (i == 11) expect_all("wrap11", 4'd1, 3'd0, 16'h0000, 0, 0);
    end
    step(0,0,1,0);
    expect_all("wrap_clr", 4'd0, 3'd0, 16'h0000, 0, 0);

    // Idle timeout after one committed digit (value 2).
    step(1,0,0,0); step(1,0,0,0); step(0,1,0,0);
    expect_all("to_load", 4'd0, 3'd1, 16'h0002, 0, 0);
    for (int i = 1; i <= 7; i++) step(0,0,0,0);
    expect_all("to_idle7", 4'd0, 3'd1, 16'h0002, 0, 0);
    step(0,0,0,0);
    expect_all("to_fire", 4'd0, 3'd0, 16'h0000, 0, 1);
    step(0,0,0,0);
    expect_all("to_after", 4'd0, 3'd0, 16'h0000, 0, 0);

    // Same again, but an increment on idle cycle 7 restarts the idle count.
    step(1,0,0,0); step(0,1,0,0);
    for (int i = 1; i <= 6; i++) step(0,0,0,0);
    step(1,0,0,0);
    for (int i = 1; i <= 7; i++) begin
      step(0,0,0,0);
      cmp("no_timeout", 32'(timeout), 32'd0);
    end
    expect_all("no_to_end", 4'd1, 3'd1, 16'h0001, 0, 0);
    step(0,0,1,0);

    // VALID lockout: no timeout while held, inc/load ignored, clear wipes everything.
    for (int i = 0; i < 4; i++) begin step(1,0,0,0); step(0,1,0,0); end
    expect_all("v_full", 4'd0, 3'd4, 16'h1111, 1, 0);
    for (int i = 0; i < 10; i++) step(0,0,0,0);
    expect_all("v_no_to", 4'd0, 3'd4, 16'h1111, 1, 0);
    step(1,0,0,0);
    expect_all("v_inc2", 4'd0, 3'd4, 16'h1111, 1, 0);
    step(0,1,0,0);
    expect_all("v_load2", 4'd0, 3'd4, 16'h1111, 1, 0);
    step(0,0,1,0);
    expect_all("v_clear", 4'd0, 3'd0, 16'h0000, 0, 0);

    // Asynchronous reset between edges with digit_out=5, digit_count=2.
    step(1,0,0,0); step(0,1,0,0); step(1,0,0,0); step(0,1,0,0);
    for (int i = 0; i < 5; i++) step(1,0,0,0);
    expect_all("pre_rst", 4'd5, 3'd2, 16'h0011, 0, 0);
    #2 rst = 1'b1;
    #1 expect_all("async_rst", 4'd0, 3'd0, 16'h0000, 0, 0);
    #1 rst = 1'b0;
    step(1,0,0,0);
    expect_all("post_rst", 4'd1, 3'd0, 16'h0000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
